// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arbiter
// Description : Round-robin arbiter/sequencer owning one WIDTH-bit register
//               shared by NREQ requesters. A winner is granted, its write
//               data is loaded, ownership is held for HOLD_CYCLES edges, and
//               priority then rotates past the winner.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   1            rising-edge clock
//   rst_n  in   1            asynchronous active-low reset
//   req    in   NREQ         level-sensitive request per requester
//   wdata  in   NREQ*WIDTH   write data, requester i at [i*WIDTH +: WIDTH]
//   clr    in   1            synchronous clear of the register (IDLE only)
//   gnt    out  NREQ         one-hot grant, zero when no owner
//   ack    out  NREQ         one-cycle load-done pulse to the owner
//   owner  out  clog2(NREQ)  index of current or last granted requester
//   busy   out  1            high whenever the sequencer is not idle
//   q      out  WIDTH        shared register contents
// ============================================================================
module shared_reg_arbiter #(
   parameter int WIDTH       = 8,
   parameter int NREQ        = 4,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     wdata,
   input  logic                      clr,
   output logic [NREQ-1:0]           gnt,
   output logic [NREQ-1:0]           ack,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      busy,
   output logic [WIDTH-1:0]          q
);

   localparam int IDX_W = $clog2(NREQ);
   // Counter only has to hold HOLD_CYCLES-1; keep at least one bit.
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   ptr_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [NREQ-1:0]    gnt_nxt;
   logic [NREQ-1:0]    ack_nxt;
   logic [IDX_W-1:0]   owner_nxt;
   logic [WIDTH-1:0]   q_nxt;
   logic               busy_nxt;

   logic               rr_found;
   logic [IDX_W-1:0]   rr_winner;
   logic [IDX_W-1:0]   rr_cand;

   // ------------------------------------------------------------------------
   // Round-robin pick: first asserted request scanning upward from ptr,
   // wrapping modulo NREQ (NREQ need not be a power of two).
   // ------------------------------------------------------------------------
   always_comb begin
      rr_found  = 1'b0;
      rr_winner = '0;
      rr_cand   = '0;
      for (int k = 0; k < NREQ; k++) begin
         rr_cand = IDX_W'((32'(ptr) + 32'(k)) % 32'(NREQ));
         if (!rr_found && req[rr_cand]) begin
            rr_found  = 1'b1;
            rr_winner = rr_cand;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and next-output logic. Every output is registered, so this
   // block computes the values that appear after the coming edge.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      ack_nxt   = '0;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      q_nxt     = q;

      unique case (state)
         IDLE: begin
            // Clear wins over any pending request.
            if (clr) begin
               q_nxt = '0;
            end else if (rr_found) begin
               owner_nxt = rr_winner;
               gnt_nxt   = NREQ'(1'b1) << rr_winner;
               state_nxt = GRANT;
            end
         end

         GRANT: begin
            if (req[owner]) begin
               q_nxt     = wdata[owner*WIDTH +: WIDTH];
               ack_nxt   = gnt;
               cnt_nxt   = HOLD_LOAD;
               state_nxt = HOLD;
            end else begin
               // Requester withdrew before the load: release without
               // rotating priority so it is not penalised.
               gnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end

         HOLD: begin
            // req and clr are deliberately ignored here.
            if (cnt == '0) begin
               gnt_nxt   = '0;
               ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end

         default: begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // ------------------------------------------------------------------------
   // State register.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Registered outputs, priority pointer, hold counter and shared register.
   // Reset clears everything at once, dropping any in-flight load.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt   <= '0;
         ack   <= '0;
         owner <= '0;
         busy  <= 1'b0;
         q     <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         gnt   <= gnt_nxt;
         ack   <= ack_nxt;
         owner <= owner_nxt;
         busy  <= busy_nxt;
         q     <= q_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule
`default_nettype wire

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

- Round-robin arbiter and sequencer that shares one WIDTH-bit D-flip-flop register among NREQ requesters.
- Each requester raises a request. The block grants the register to one requester, loads that requester's write data, and holds ownership for a fixed settle window. It then moves priority past the winner.
- Sits between the requesting datapath blocks and the shared register bank, which is the only storage it owns.

## Interface
Parameters:
- WIDTH, 8, width of the shared register and of each requester's write data
- NREQ, 4, number of requesters; supported range 2..8
- HOLD_CYCLES, 2, number of cycles ownership is held after a load; must be ≥1

Ports:
- Clock  input  1  single clock; all state changes on its rising edge
- Reset  input  1  asynchronous, active-low reset
- req  input  NREQ  request per requester; level-sensitive
- wdata  input  NREQ*WIDTH  flattened write data; requester i occupies bits [i*WIDTH +: WIDTH]
- clr  input  1  synchronous clear request for the shared register
- gnt  output  NREQ  one-hot grant; all zero when no owner
- ack  output  NREQ  one-cycle load-done pulse to the owner
- owner  output  $clog2(NREQ)  index of the current or last granted requester
- busy  output  1  high whenever state ≠ IDLE
- q  output  WIDTH  shared register contents

## Operation
- Reset (asynchronous, while Reset is low): state=IDLE, q=0, gnt=0, ack=0, owner=0, busy=0, priority pointer ptr=0 (requester 0 has priority first).
- The FSM has three states: IDLE, GRANT, HOLD.
- IDLE with clr=1:
  - q←0 at the edge.
  - No grant is issued, even if requests are pending; clr beats req.
  - State stays IDLE.
- IDLE with clr=0 and req≠0:
  - Pick the first asserted req scanning from ptr upward, wrapping modulo NREQ.
  - owner←winner, gnt←onehot(winner), state←GRANT.
- IDLE with clr=0 and req=0: remain in IDLE, all outputs hold.
- GRANT with req[owner]=1:
  - q←wdata slice of owner.
  - ack[owner] is high for exactly the next cycle.
  - A hold counter loads HOLD_CYCLES−1; state←HOLD.
- GRANT with req[owner]=0 (abort):
  - gnt←0, no load, no ack, ptr unchanged.
  - state←IDLE.
- HOLD:
  - gnt stays high and q is frozen.
  - req and clr are ignored.
  - The counter decrements each edge.
  - When the counter reaches 0: gnt←0, ptr←(owner+1) mod NREQ, state←IDLE.
- clr is honoured only in IDLE. An assertion in GRANT or HOLD has no effect unless clr is still high once the FSM returns to IDLE.
- Dropping req during HOLD does not shorten the hold.
- owner keeps its last value in IDLE.

## Timing
- Cycle numbering: edge E0 is the IDLE edge that samples a request.
- From E0 onward: gnt one-hot, busy=1.
- E1 (GRANT): q updates. ack is high from E1 to E2.
- HOLD runs E1 … E1+HOLD_CYCLES.
- gnt and busy drop at E1+HOLD_CYCLES.
- Earliest next grant appears at edge E2+HOLD_CYCLES.
- Grant throughput: one grant per HOLD_CYCLES+2 cycles.
- Request to load latency: 2 edges (E0 sample, E1 load).
- clr in IDLE: q=0 one edge later.
- All outputs are registered; no combinational path from inputs to outputs.
- Asynchronous Reset mid-GRANT or mid-HOLD:
  - Immediately forces the reset values, including q=0.
  - An in-flight load is lost and no ack is issued.

## Test plan
All scenarios use WIDTH=8, NREQ=4, HOLD_CYCLES=2.
- Reset values: pulse Reset low with req=4'b1111 → q=0, gnt=0, ack=0, busy=0, owner=0. The first grant after release goes to requester 0.
- Single requester: req=4'b0100, wdata[2]=8'hA5.
  - After E0: gnt=4'b0100, owner=2.
  - After E1: q=8'hA5 and ack=4'b0100 for one cycle.
  - gnt drops after E3.
- Round-robin: req=4'b1111 held, with wdata i = 8'h10+i.
  - Grant order is 0,1,2,3,0.
  - q sequence is 10,11,12,13,10.
  - Grants arrive every 4 cycles.
- Abort: req=4'b0010 for one cycle only → gnt=4'b0010 for one cycle, then 0; q unchanged, no ack. The next grant with req=4'b0011 goes to 0, because ptr was not advanced.
- clr priority:
  - In IDLE with q=8'h3C: clr=1 with req=4'b0001 → q=0 after one edge, no gnt that cycle. With clr=0, requester 0 is granted next edge.
  - clr pulsed during HOLD → ignored; q keeps the loaded value.
- Reset mid-HOLD: load 8'hFF, assert Reset low in the first HOLD cycle → q=0, gnt=0, busy=0 immediately, without waiting for a clock edge. After release, the first grant uses ptr=0.
